// File: rtl/uart_pkg.sv
// uart_pkg: shared UART types, frame constants and parity-mode decoding
package uart_pkg;
  localparam int UART_DATA_BITS = 8;
  typedef enum logic [1:0] {NONE = 2'd0, EVEN = 2'd1, ODD = 2'd2} parity_mode_e;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_HIGH} rx_state_e;
  function automatic parity_mode_e to_mode(input logic [1:0] m);
    return (m == 2'd3) ? NONE : parity_mode_e'(m);
  endfunction
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for an asynchronous input, reset value selectable
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic nreset,
  input  logic d,
  output logic q
);
  logic s1;
  // metastability filter: d -> s1 -> q
  always_ff @(posedge clk)
    if (!nreset) {q, s1} <= {RST_VAL, RST_VAL};
    else {q, s1} <= {s1, d};
endmodule

// File: rtl/uart_rx_deserializer.sv
// uart_rx_deserializer: UART receiver turning the serial line into a valid/ready byte stream
module uart_rx_deserializer
  import uart_pkg::*;
#(
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 nreset,
  input  logic                 rx,
  input  logic [DIV_WIDTH-1:0] divisor,
  input  logic [1:0]           parity_mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [7:0]           out_data,
  output logic                 out_parity_err,
  output logic                 out_frame_err,
  output logic                 overrun,
  input  logic                 overrun_clr,
  output logic                 busy
);
  localparam logic [2:0] LAST_BIT = 3'(UART_DATA_BITS - 1);
  rx_state_e state, state_n;
  parity_mode_e mode_l, mode_n;
  logic [DIV_WIDTH-1:0] cnt, cnt_n, div_l, div_n;
  logic [2:0] bitidx, bitidx_n;
  logic [UART_DATA_BITS-1:0] shift, shift_n;
  logic rxs, rxs_d, perr, perr_n, samp, deliver, ferr, xfer, load;
  sync_2ff #(.RST_VAL(1'b1)) u_sync (.clk(clk), .nreset(nreset), .d(rx), .q(rxs));
  assign busy = state != IDLE;
  assign samp = cnt == '0;
  assign xfer = out_valid & out_ready;
  assign load = deliver & (~out_valid | xfer);
  // frame state, bit timer and shift register
  always_ff @(posedge clk)
    if (!nreset) begin
      state  <= IDLE;
      mode_l <= NONE;
      cnt    <= '0;
      div_l  <= '0;
      bitidx <= '0;
      shift  <= '0;
      perr   <= 1'b0;
      rxs_d  <= 1'b1;
    end else begin
      state  <= state_n;
      mode_l <= mode_n;
      cnt    <= cnt_n;
      div_l  <= div_n;
      bitidx <= bitidx_n;
      shift  <= shift_n;
      perr   <= perr_n;
      rxs_d  <= rxs;
    end
  // next-state decode; every sample point reloads the bit timer with a full period
  always_comb begin
    state_n  = state;
    mode_n   = mode_l;
    div_n    = div_l;
    cnt_n    = cnt - DIV_WIDTH'(1);
    bitidx_n = bitidx;
    shift_n  = shift;
    perr_n   = perr;
    deliver  = 1'b0;
    ferr     = 1'b0;
    if (state != IDLE && samp) cnt_n = div_l - DIV_WIDTH'(1);
    case (state)
      IDLE: begin
        div_n  = divisor;
        mode_n = to_mode(parity_mode);
        if (rxs_d & ~rxs) begin
          state_n = START;
          cnt_n   = divisor >> 1;
        end
      end
      START: if (samp) begin
        state_n  = rxs ? IDLE : DATA;
        bitidx_n = '0;
        perr_n   = 1'b0;
      end
      DATA: if (samp) begin
        shift_n  = {rxs, shift[UART_DATA_BITS-1:1]};
        bitidx_n = bitidx + 3'd1;
        if (bitidx == LAST_BIT) state_n = (mode_l == NONE) ? STOP : PARITY;
      end
      PARITY: if (samp) begin
        perr_n  = rxs ^ (^shift) ^ (mode_l == ODD);
        state_n = STOP;
      end
      STOP: if (samp) begin
        deliver = 1'b1;
        ferr    = ~rxs;
        state_n = rxs ? IDLE : WAIT_HIGH;
      end
      WAIT_HIGH: if (rxs) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  // single-entry output register; a frame finishing while it is full is dropped and flagged
  always_ff @(posedge clk)
    if (!nreset) begin
      out_valid      <= 1'b0;
      out_data       <= '0;
      out_parity_err <= 1'b0;
      out_frame_err  <= 1'b0;
      overrun        <= 1'b0;
    end else begin
      out_valid <= load | (out_valid & ~xfer);
      overrun   <= (deliver & ~load) | (overrun & ~overrun_clr);
      if (load) begin
        out_data       <= shift;
        out_parity_err <= perr;
        out_frame_err  <= ferr;
      end
    end
endmodule

// File: tb/tb_uart_rx_deserializer.sv
// tb_uart_rx_deserializer: directed frames with a scoreboard-driven output monitor
module tb_uart_rx_deserializer;
  typedef struct packed {logic [7:0] d; logic p; logic f;} exp_t;
  logic clk = 1'b0, nreset = 1'b0, rx = 1'b1, out_ready = 1'b1, overrun_clr = 1'b0;
  logic [15:0] divisor = 16'd3;
  logic [1:0] parity_mode = 2'd1;
  logic out_valid, out_parity_err, out_frame_err, overrun, busy, seen;
  logic [7:0] out_data;
  exp_t q[$];
  exp_t e;
  int vecs = 0, errs = 0, delivered = 0, lat = 0, base = 0;
  uart_rx_deserializer #(.DIV_WIDTH(16)) dut (
    .clk(clk), .nreset(nreset), .rx(rx), .divisor(divisor), .parity_mode(parity_mode),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_parity_err(out_parity_err), .out_frame_err(out_frame_err),
    .overrun(overrun), .overrun_clr(overrun_clr), .busy(busy)
  );
  always #5 clk = ~clk;
  // monitor: every accepted byte must match the oldest expected entry
  always @(negedge clk)
    if (nreset && out_valid && out_ready) begin
      vecs++;
      delivered++;
      if (q.size() == 0) begin
        errs++;
        $display("FAIL unexpected_byte: got data=%02h perr=%0b ferr=%0b, required none", out_data, out_parity_err, out_frame_err);
      end else begin
        e = q.pop_front();
        if ({out_data, out_parity_err, out_frame_err} !== e) begin
          errs++;
          $display("FAIL byte: got data=%02h perr=%0b ferr=%0b, required data=%02h perr=%0b ferr=%0b",
                   out_data, out_parity_err, out_frame_err, e.d, e.p, e.f);
        end
      end
    end
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    vecs++;
    if (act !== req) begin
      errs++;
      $display("FAIL %s: got %0h, required %0h", nm, act, req);
    end
  endtask
  task automatic send(input logic [7:0] d, input logic pen, input logic pbit, input logic sbit,
                      input logic idle_after, input int div);
    rx = 1'b0;
    tick(div);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      tick(div);
    end
    if (pen) begin
      rx = pbit;
      tick(div);
    end
    rx = sbit;
    tick(div);
    rx = idle_after;
  endtask
  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 300) begin
      tick(1);
      n++;
    end
    check("drain", q.size(), 0);
  endtask
  initial begin
    tick(4);
    check("rst_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_overrun", overrun, 0);
    check("rst_data", out_data, 0);
    nreset = 1'b1;
    tick(4);
    q.push_back('{8'hA5, 1'b0, 1'b0});
    fork
      send(8'hA5, 1'b1, 1'b0, 1'b1, 1'b1, 3);
      begin
        int n = 0;
        @(posedge clk);
        while (!out_valid && n < 200) begin
          @(posedge clk);
          #1;
          n++;
        end
        lat = n;
      end
    join
    check("latency", lat, 34);
    drain();
    parity_mode = 2'd2;
    q.push_back('{8'h3C, 1'b1, 1'b0});
    send(8'h3C, 1'b1, 1'b0, 1'b1, 1'b1, 3);
    q.push_back('{8'h3C, 1'b0, 1'b0});
    send(8'h3C, 1'b1, 1'b1, 1'b1, 1'b1, 3);
    drain();
    parity_mode = 2'd1;
    base = delivered;
    q.push_back('{8'h55, 1'b0, 1'b1});
    send(8'h55, 1'b1, 1'b0, 1'b0, 1'b0, 3);
    tick(60);
    check("break_busy", busy, 1);
    check("break_one_byte", delivered - base, 1);
    rx = 1'b1;
    tick(6);
    check("break_idle", busy, 0);
    q.push_back('{8'h5A, 1'b0, 1'b0});
    send(8'h5A, 1'b1, 1'b0, 1'b1, 1'b1, 3);
    drain();
    divisor = 16'd16;
    base = delivered;
    rx = 1'b0;
    tick(4);
    check("glitch_busy", busy, 1);
    rx = 1'b1;
    tick(40);
    check("glitch_idle", busy, 0);
    check("glitch_no_byte", delivered - base, 0);
    divisor = 16'd3;
    parity_mode = 2'd0;
    out_ready = 1'b0;
    q.push_back('{8'h11, 1'b0, 1'b0});
    send(8'h11, 1'b0, 1'b0, 1'b1, 1'b1, 3);
    send(8'h22, 1'b0, 1'b0, 1'b1, 1'b1, 3);
    tick(5);
    check("ovr_valid", out_valid, 1);
    check("ovr_data", out_data, 8'h11);
    check("ovr_flag", overrun, 1);
    overrun_clr = 1'b1;
    tick(1);
    overrun_clr = 1'b0;
    check("ovr_clr", overrun, 0);
    overrun_clr = 1'b1;
    seen = 1'b0;
    fork
      send(8'h33, 1'b0, 1'b0, 1'b1, 1'b1, 3);
      repeat (60) begin
        @(posedge clk);
        #1;
        if (overrun) seen = 1'b1;
      end
    join
    overrun_clr = 1'b0;
    check("ovr_set_beats_clr", seen, 1);
    check("ovr_data_held", out_data, 8'h11);
    send(8'h44, 1'b0, 1'b0, 1'b1, 1'b1, 3);
    tick(5);
    check("ovr_flag2", overrun, 1);
    out_ready = 1'b1;
    drain();
    tick(2);
    check("ovr_drained", out_valid, 0);
    parity_mode = 2'd1;
    rx = 1'b0;
    tick(3);
    for (int i = 0; i < 4; i++) begin
      rx = 1'b0;
      tick(3);
    end
    rx = 1'b1;
    tick(1);
    nreset = 1'b0;
    tick(1);
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_data", out_data, 0);
    check("mid_rst_perr", out_parity_err, 0);
    check("mid_rst_ferr", out_frame_err, 0);
    check("mid_rst_overrun", overrun, 0);
    check("mid_rst_busy", busy, 0);
    nreset = 1'b1;
    tick(12);
    q.push_back('{8'h81, 1'b0, 1'b0});
    send(8'h81, 1'b1, 1'b0, 1'b1, 1'b1, 3);
    drain();
    tick(10);
    check("final_queue", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
